// File: rtl/bf_bus_pkg.sv
// Shared encodings for the brainfuck bus controller: FSM states, RAM owner
// identity and the sizing helper for the RAM wait counter.
package bf_bus_pkg;

  typedef enum logic [1:0] {
    R_IDLE,
    R_CMD,
    R_WAIT,
    R_RESP
  } ram_state_e;

  typedef enum logic [1:0] {
    IO_IDLE,
    IO_TX,
    IO_RX,
    IO_RESP
  } io_state_e;

  typedef enum logic {
    OWN_CPU  = 1'b0,
    OWN_HOST = 1'b1
  } owner_e;

  function automatic int unsigned lat_cnt_width(input int unsigned lat);
    return $clog2(lat + 1);
  endfunction

endpackage

// File: rtl/bf_rr_arbiter2.sv
// Two-requester round-robin grant. last_grant advances only when the served
// transaction completes, so an abandoned grant does not move the priority.
module bf_rr_arbiter2
  import bf_bus_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   req_cpu_i,
  input  logic   req_host_i,
  input  logic   upd_i,
  input  owner_e upd_owner_i,
  output logic   gnt_valid_o,
  output owner_e gnt_owner_o
);

  owner_e last_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= OWN_HOST;
    end else if (upd_i) begin
      last_q <= upd_owner_i;
    end
  end

  always_comb begin
    gnt_valid_o = req_cpu_i | req_host_i;
    gnt_owner_o = OWN_CPU;
    if (req_cpu_i && req_host_i) begin
      gnt_owner_o = (last_q == OWN_CPU) ? OWN_HOST : OWN_CPU;
    end else if (req_host_i) begin
      gnt_owner_o = OWN_HOST;
    end
  end

endmodule

// File: rtl/bf_bus_ctrl.sv
// Bus controller: CPU strobe decode, round-robin shared data RAM (CPU/host)
// and console TX/RX streams, each transaction closed by a one-cycle pulse.
module bf_bus_ctrl
  import bf_bus_pkg::*;
#(
  parameter int unsigned DATA_ADDR_WIDTH = 8,
  parameter int unsigned RAM_LATENCY     = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_ADDR_WIDTH-1:0] cpu_addr_i,
  input  logic [7:0]                 cpu_wdata_i,
  output logic [7:0]                 cpu_rdata_o,
  input  logic                       cpu_rd_i,
  input  logic                       cpu_wr_i,
  input  logic                       cpu_mreq_i,
  input  logic                       cpu_ioreq_i,
  output logic                       cpu_ready_o,
  input  logic                       host_req_i,
  input  logic                       host_we_i,
  input  logic [DATA_ADDR_WIDTH-1:0] host_addr_i,
  input  logic [7:0]                 host_wdata_i,
  output logic [7:0]                 host_rdata_o,
  output logic                       host_ack_o,
  output logic                       ram_en_o,
  output logic                       ram_we_o,
  output logic [DATA_ADDR_WIDTH-1:0] ram_addr_o,
  output logic [7:0]                 ram_wdata_o,
  input  logic [7:0]                 ram_rdata_i,
  output logic [7:0]                 tx_data_o,
  output logic                       tx_valid_o,
  input  logic                       tx_ready_i,
  input  logic [7:0]                 rx_data_i,
  input  logic                       rx_valid_i,
  output logic                       rx_ready_o
);

  localparam int unsigned   CW        = lat_cnt_width(RAM_LATENCY);
  localparam logic [CW-1:0] LAST_WAIT = CW'(RAM_LATENCY - 1);

  logic cpu_any, cpu_io_req, cpu_mem_req;

  // ioreq takes precedence over mreq; wr over rd is applied where latched
  assign cpu_any     = cpu_rd_i | cpu_wr_i;
  assign cpu_io_req  = cpu_ioreq_i & cpu_any;
  assign cpu_mem_req = cpu_mreq_i & ~cpu_ioreq_i & cpu_any;

  ram_state_e                 r_state_q, r_state_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  owner_e                     own_q, gnt_owner;
  logic                       gnt_valid, we_q, rd_cap;
  logic                       arb_req_cpu, arb_req_host, arb_upd;
  logic [DATA_ADDR_WIDTH-1:0] addr_q;
  logic [7:0]                 wdata_q, cpu_rdata_q, host_rdata_q, tx_data_q;
  logic                       ram_cpu_pulse, io_pulse;
  io_state_e                  io_state_q, io_state_d;

  assign arb_req_cpu  = cpu_mem_req & (r_state_q == R_IDLE);
  assign arb_req_host = host_req_i & (r_state_q == R_IDLE);
  assign arb_upd      = (r_state_q == R_RESP);

  bf_rr_arbiter2 u_arb (
    .clk        (clk),
    .rst        (rst),
    .req_cpu_i  (arb_req_cpu),
    .req_host_i (arb_req_host),
    .upd_i      (arb_upd),
    .upd_owner_i(own_q),
    .gnt_valid_o(gnt_valid),
    .gnt_owner_o(gnt_owner)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state_q <= R_IDLE;
      cnt_q     <= '0;
    end else begin
      r_state_q <= r_state_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    r_state_d = r_state_q;
    cnt_d     = cnt_q;
    case (r_state_q)
      R_IDLE: if (gnt_valid) r_state_d = R_CMD;
      R_CMD: begin
        r_state_d = R_WAIT;
        cnt_d     = '0;
      end
      R_WAIT: begin
        if (cnt_q == LAST_WAIT) r_state_d = R_RESP;
        else                    cnt_d     = cnt_q + 1'b1;
      end
      R_RESP:  r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    ram_en_o      = 1'b0;
    ram_we_o      = 1'b0;
    ram_cpu_pulse = 1'b0;
    host_ack_o    = 1'b0;
    case (r_state_q)
      R_CMD: begin
        ram_en_o = 1'b1;
        ram_we_o = we_q;
      end
      R_RESP: begin
        ram_cpu_pulse = (own_q == OWN_CPU);
        host_ack_o    = (own_q == OWN_HOST);
      end
      default: ;
    endcase
  end

  assign ram_addr_o  = addr_q;
  assign ram_wdata_o = wdata_q;
  assign rd_cap      = (r_state_q == R_WAIT) && (cnt_q == LAST_WAIT) && !we_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      own_q   <= OWN_HOST;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (r_state_q == R_IDLE && gnt_valid) begin
      own_q <= gnt_owner;
      if (gnt_owner == OWN_CPU) begin
        we_q    <= cpu_wr_i;
        addr_q  <= cpu_addr_i;
        wdata_q <= cpu_wdata_i;
      end else begin
        we_q    <= host_we_i;
        addr_q  <= host_addr_i;
        wdata_q <= host_wdata_i;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      host_rdata_q <= '0;
    end else if (rd_cap && own_q == OWN_HOST) begin
      host_rdata_q <= ram_rdata_i;
    end
  end

  // RAM read and console RX share the CPU data register; they never overlap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpu_rdata_q <= '0;
    end else if (rd_cap && own_q == OWN_CPU) begin
      cpu_rdata_q <= ram_rdata_i;
    end else if (io_state_q == IO_RX && rx_valid_i) begin
      cpu_rdata_q <= rx_data_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      io_state_q <= IO_IDLE;
    end else begin
      io_state_q <= io_state_d;
    end
  end

  always_comb begin
    io_state_d = io_state_q;
    case (io_state_q)
      IO_IDLE: if (cpu_io_req) io_state_d = cpu_wr_i ? IO_TX : IO_RX;
      IO_TX:   if (tx_ready_i) io_state_d = IO_RESP;
      IO_RX:   if (rx_valid_i) io_state_d = IO_RESP;
      IO_RESP: io_state_d = IO_IDLE;
      default: io_state_d = IO_IDLE;
    endcase
  end

  always_comb begin
    tx_valid_o = 1'b0;
    rx_ready_o = 1'b0;
    io_pulse   = 1'b0;
    case (io_state_q)
      IO_TX:   tx_valid_o = 1'b1;
      IO_RX:   rx_ready_o = 1'b1;
      IO_RESP: io_pulse   = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_data_q <= '0;
    end else if (io_state_q == IO_IDLE && cpu_io_req && cpu_wr_i) begin
      tx_data_q <= cpu_wdata_i;
    end
  end

  assign tx_data_o    = tx_data_q;
  assign cpu_rdata_o  = cpu_rdata_q;
  assign host_rdata_o = host_rdata_q;
  assign cpu_ready_o  = ram_cpu_pulse | io_pulse;

endmodule

// File: tb/tb_bf_bus_ctrl.sv
// Bench for bf_bus_ctrl: RAM_LATENCY=1 instance with full traffic, plus a
// RAM_LATENCY=3 instance exercised by the CPU only.
module tb_bf_bus_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] cpu_addr_i, cpu_wdata_i, cpu_rdata_o;
  logic       cpu_rd_i, cpu_wr_i, cpu_mreq_i, cpu_ioreq_i, cpu_ready_o;
  logic       host_req_i, host_we_i, host_ack_o;
  logic [7:0] host_addr_i, host_wdata_i, host_rdata_o;
  logic       ram_en_o, ram_we_o;
  logic [7:0] ram_addr_o, ram_wdata_o, ram_rdata_i;
  logic [7:0] tx_data_o, rx_data_i;
  logic       tx_valid_o, tx_ready_i, rx_valid_i, rx_ready_o;

  logic [7:0] c3_addr, c3_wdata, c3_rdata, c3_host_rdata, c3_tx_data;
  logic       c3_rd, c3_wr, c3_mreq, c3_ready, c3_host_ack, c3_tx_valid, c3_rx_ready;
  logic       c3_ram_en, c3_ram_we;
  logic [7:0] c3_ram_addr, c3_ram_wdata, c3_ram_rdata;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_mem [256];

  always #5 clk = ~clk;

  bf_bus_ctrl #(.DATA_ADDR_WIDTH(8), .RAM_LATENCY(1)) u_dut (
    .clk(clk), .rst(rst),
    .cpu_addr_i(cpu_addr_i), .cpu_wdata_i(cpu_wdata_i), .cpu_rdata_o(cpu_rdata_o),
    .cpu_rd_i(cpu_rd_i), .cpu_wr_i(cpu_wr_i), .cpu_mreq_i(cpu_mreq_i),
    .cpu_ioreq_i(cpu_ioreq_i), .cpu_ready_o(cpu_ready_o),
    .host_req_i(host_req_i), .host_we_i(host_we_i), .host_addr_i(host_addr_i),
    .host_wdata_i(host_wdata_i), .host_rdata_o(host_rdata_o), .host_ack_o(host_ack_o),
    .ram_en_o(ram_en_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
    .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i),
    .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
    .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o)
  );

  bf_bus_ctrl #(.DATA_ADDR_WIDTH(8), .RAM_LATENCY(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .cpu_addr_i(c3_addr), .cpu_wdata_i(c3_wdata), .cpu_rdata_o(c3_rdata),
    .cpu_rd_i(c3_rd), .cpu_wr_i(c3_wr), .cpu_mreq_i(c3_mreq),
    .cpu_ioreq_i(1'b0), .cpu_ready_o(c3_ready),
    .host_req_i(1'b0), .host_we_i(1'b0), .host_addr_i(8'h00),
    .host_wdata_i(8'h00), .host_rdata_o(c3_host_rdata), .host_ack_o(c3_host_ack),
    .ram_en_o(c3_ram_en), .ram_we_o(c3_ram_we), .ram_addr_o(c3_ram_addr),
    .ram_wdata_o(c3_ram_wdata), .ram_rdata_i(c3_ram_rdata),
    .tx_data_o(c3_tx_data), .tx_valid_o(c3_tx_valid), .tx_ready_i(1'b0),
    .rx_data_i(8'h00), .rx_valid_i(1'b0), .rx_ready_o(c3_rx_ready)
  );

  logic [45:0] outs1, outs3;
  assign outs1 = {cpu_rdata_o, cpu_ready_o, host_rdata_o, host_ack_o, ram_en_o, ram_we_o,
                  ram_addr_o, ram_wdata_o, tx_data_o, tx_valid_o, rx_ready_o};
  assign outs3 = {c3_rdata, c3_ready, c3_host_rdata, c3_host_ack, c3_ram_en, c3_ram_we,
                  c3_ram_addr, c3_ram_wdata, c3_tx_data, c3_tx_valid, c3_rx_ready};

  // Environment RAMs; junk is returned whenever no read is due
  logic [7:0] mem1 [256];
  logic [7:0] mem3 [256];
  logic [7:0] p3 [3];
  always @(posedge clk) begin
    if (ram_en_o && !ram_we_o) ram_rdata_i <= mem1[ram_addr_o];
    else                       ram_rdata_i <= 8'($urandom);
    if (ram_en_o && ram_we_o)  mem1[ram_addr_o] <= ram_wdata_o;
  end
  always @(posedge clk) begin
    if (c3_ram_en && !c3_ram_we) p3[0] <= mem3[c3_ram_addr];
    else                         p3[0] <= 8'($urandom);
    p3[1] <= p3[0];
    p3[2] <= p3[1];
    if (c3_ram_en && c3_ram_we)  mem3[c3_ram_addr] <= c3_ram_wdata;
  end
  assign c3_ram_rdata = p3[2];

  int cyc = 0, en_cnt = 0, we_cnt = 0, rdy_cnt = 0, ack_cnt = 0, rdy3_cnt = 0, we_glitch = 0;
  logic [7:0] last_en_addr = '0, last_en_data = '0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (ram_en_o) begin
      en_cnt       <= en_cnt + 1;
      last_en_addr <= ram_addr_o;
      last_en_data <= ram_wdata_o;
      if (ram_we_o) we_cnt <= we_cnt + 1;
    end
    if (ram_we_o && !ram_en_o) we_glitch <= we_glitch + 1;
    if (cpu_ready_o) rdy_cnt <= rdy_cnt + 1;
    if (host_ack_o) ack_cnt <= ack_cnt + 1;
    if (c3_ready) rdy3_cnt <= rdy3_cnt + 1;
  end

  task automatic cpu_mem(input bit rd, input bit wr, input logic [7:0] a, input logic [7:0] d,
                         output int lat, output logic [7:0] rdata);
    cpu_addr_i = a; cpu_wdata_i = d; cpu_rd_i = rd; cpu_wr_i = wr; cpu_mreq_i = 1'b1;
    lat = -1; rdata = 'x;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (cpu_ready_o) begin lat = k; rdata = cpu_rdata_o; break; end
    end
    @(posedge clk); #1;
    cpu_rd_i = 1'b0; cpu_wr_i = 1'b0; cpu_mreq_i = 1'b0;
  endtask

  task automatic host_mem(input bit we, input logic [7:0] a, input logic [7:0] d,
                          output int lat, output logic [7:0] rdata);
    host_addr_i = a; host_wdata_i = d; host_we_i = we; host_req_i = 1'b1;
    lat = -1; rdata = 'x;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (host_ack_o) begin lat = k; rdata = host_rdata_o; break; end
    end
    @(posedge clk); #1;
    host_req_i = 1'b0;
  endtask

  task automatic cpu3_mem(input bit wr, input logic [7:0] a, input logic [7:0] d,
                          output int lat, output logic [7:0] rdata);
    c3_addr = a; c3_wdata = d; c3_rd = !wr; c3_wr = wr; c3_mreq = 1'b1;
    lat = -1; rdata = 'x;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (c3_ready) begin lat = k; rdata = c3_rdata; break; end
    end
    @(posedge clk); #1;
    c3_rd = 1'b0; c3_wr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (outs1 !== '0) begin n_err++; $display("FAIL reset_outs got=%h exp=0", outs1); end
    n_cmp++; if (outs3 !== '0) begin n_err++; $display("FAIL reset_outs3 got=%h exp=0", outs3); end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (outs1 !== '0) begin n_err++; $display("FAIL idle_outs got=%h exp=0", outs1); end
    @(posedge clk); #1;
  endtask

  task automatic test_cpu_write_read();
    int lat, e0, w0;
    logic [7:0] rd;
    e0 = en_cnt; w0 = we_cnt;
    cpu_mem(1'b0, 1'b1, 8'h10, 8'h5A, lat, rd);
    exp_mem[8'h10] = 8'h5A;
    n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL wr_latency got=%0d exp=3", lat); end
    n_cmp++; if (en_cnt - e0 !== 1) begin n_err++; $display("FAIL wr_en_cycles got=%0d exp=1", en_cnt - e0); end
    n_cmp++; if (we_cnt - w0 !== 1) begin n_err++; $display("FAIL wr_we_cycles got=%0d exp=1", we_cnt - w0); end
    n_cmp++; if (last_en_addr !== 8'h10 || last_en_data !== 8'h5A) begin
      n_err++; $display("FAIL wr_ram_bus got=%h/%h exp=10/5a", last_en_addr, last_en_data); end
    @(negedge clk);
    n_cmp++; if (cpu_ready_o !== 1'b0) begin n_err++; $display("FAIL wr_single_pulse got=1 exp=0"); end
    @(posedge clk); #1;
    w0 = we_cnt;
    cpu_mem(1'b1, 1'b0, 8'h10, 8'h00, lat, rd);
    n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL rd_latency got=%0d exp=3", lat); end
    n_cmp++; if (rd !== 8'h5A) begin n_err++; $display("FAIL rd_data got=%h exp=5a", rd); end
    n_cmp++; if (we_cnt !== w0) begin n_err++; $display("FAIL rd_no_we got=%0d exp=%0d", we_cnt, w0); end
  endtask

  task automatic test_preload();
    int lat;
    logic [7:0] d, rd;
    for (int a = 0; a < 256; a++) begin
      d = 8'($urandom);
      exp_mem[a] = d;
      if (a[0]) host_mem(1'b1, 8'(a), d, lat, rd);
      else      cpu_mem(1'($urandom), 1'b1, 8'(a), d, lat, rd);
      n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL preload_lat a=%0d got=%0d exp=3", a, lat); end
    end
  endtask

  task automatic test_contention();
    int t_prev, t_now;
    bit got, cpu_won, expect_cpu;
    logic [7:0] ca, ha;
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0; @(posedge clk); #1;
    ca = 8'($urandom); ha = 8'($urandom);
    cpu_addr_i = ca; cpu_rd_i = 1'b1; cpu_wr_i = 1'b0; cpu_mreq_i = 1'b1;
    host_addr_i = ha; host_we_i = 1'b0; host_req_i = 1'b1;
    expect_cpu = 1'b1; t_prev = cyc;
    for (int s = 0; s < 8; s++) begin
      got = 1'b0;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (cpu_ready_o || host_ack_o) begin got = 1'b1; break; end
      end
      n_cmp++; if (!got) begin n_err++; $display("FAIL cont_timeout step=%0d got=none exp=pulse", s); break; end
      t_now = cyc;
      cpu_won = cpu_ready_o;
      n_cmp++; if (cpu_ready_o && host_ack_o) begin n_err++; $display("FAIL cont_both step=%0d got=2 exp=1", s); end
      n_cmp++; if (cpu_won !== expect_cpu) begin
        n_err++; $display("FAIL cont_order step=%0d got_cpu=%0b exp_cpu=%0b", s, cpu_won, expect_cpu); end
      n_cmp++;
      if (cpu_won ? (cpu_rdata_o !== exp_mem[ca]) : (host_rdata_o !== exp_mem[ha])) begin
        n_err++; $display("FAIL cont_data step=%0d got=%h/%h exp=%h/%h", s, cpu_rdata_o, host_rdata_o,
                          exp_mem[ca], exp_mem[ha]); end
      n_cmp++; if (t_now - t_prev !== ((s == 0) ? 3 : 4)) begin
        n_err++; $display("FAIL cont_spacing step=%0d got=%0d exp=%0d", s, t_now - t_prev, (s == 0) ? 3 : 4); end
      t_prev = t_now;
      expect_cpu = !expect_cpu;
      @(posedge clk); #1;
      if (cpu_won) begin ca = 8'($urandom); cpu_addr_i = ca; end
      else begin ha = 8'($urandom); host_addr_i = ha; end
    end
    cpu_rd_i = 1'b0; cpu_mreq_i = 1'b0; host_req_i = 1'b0;
  endtask

  task automatic test_io_rx_block();
    int lat, e0, r0, start;
    bit bad;
    logic [7:0] rd;
    cpu_ioreq_i = 1'b1; cpu_rd_i = 1'b1; cpu_wr_i = 1'b0; cpu_mreq_i = 1'b1;
    rx_valid_i = 1'b0; rx_data_i = 8'h00;
    e0 = en_cnt; r0 = rdy_cnt; start = cyc;
    host_mem(1'b1, 8'h03, 8'hFF, lat, rd);
    exp_mem[3] = 8'hFF;
    n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL io_host_lat got=%0d exp=3", lat); end
    n_cmp++; if (en_cnt - e0 !== 1) begin n_err++; $display("FAIL io_mreq_ignored got=%0d exp=1", en_cnt - e0); end
    bad = 1'b0;
    while (cyc - start < 20) begin
      @(negedge clk);
      if (cyc - start >= 1 && (rx_ready_o !== 1'b1 || cpu_ready_o !== 1'b0)) bad = 1'b1;
      @(posedge clk); #1;
    end
    n_cmp++; if (bad) begin n_err++; $display("FAIL rx_stall got=bad exp=rx_ready_held"); end
    rx_data_i = 8'h41; rx_valid_i = 1'b1;
    @(posedge clk); #1;
    rx_valid_i = 1'b0;
    lat = -1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (cpu_ready_o) begin lat = k; rd = cpu_rdata_o; break; end
    end
    n_cmp++; if (lat !== 0) begin n_err++; $display("FAIL rx_lat got=%0d exp=0", lat); end
    n_cmp++; if (rd !== 8'h41) begin n_err++; $display("FAIL rx_data got=%h exp=41", rd); end
    @(posedge clk); #1;
    cpu_ioreq_i = 1'b0; cpu_rd_i = 1'b0; cpu_mreq_i = 1'b0;
    repeat (4) @(posedge clk); #1;
    n_cmp++; if (rdy_cnt - r0 !== 1) begin n_err++; $display("FAIL rx_pulses got=%0d exp=1", rdy_cnt - r0); end
  endtask

  task automatic test_io_tx();
    int lat, e0, r0;
    bit bad;
    e0 = en_cnt; r0 = rdy_cnt;
    cpu_ioreq_i = 1'b1; cpu_rd_i = 1'b1; cpu_wr_i = 1'b1; cpu_mreq_i = 1'b0;
    cpu_wdata_i = 8'h48; tx_ready_i = 1'b0;
    @(posedge clk); #1;
    cpu_wdata_i = 8'hC3;
    bad = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (tx_valid_o !== 1'b1 || tx_data_o !== 8'h48 || cpu_ready_o !== 1'b0) bad = 1'b1;
    end
    n_cmp++; if (bad) begin n_err++; $display("FAIL tx_hold got=v%0b/%h exp=v1/48", tx_valid_o, tx_data_o); end
    @(posedge clk); #1; tx_ready_i = 1'b1;
    @(posedge clk); #1; tx_ready_i = 1'b0;
    lat = -1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (cpu_ready_o) begin lat = k; break; end
    end
    n_cmp++; if (lat !== 0) begin n_err++; $display("FAIL tx_lat got=%0d exp=0", lat); end
    @(posedge clk); #1;
    cpu_ioreq_i = 1'b0; cpu_rd_i = 1'b0; cpu_wr_i = 1'b0;
    repeat (3) @(posedge clk); #1;
    n_cmp++; if (rdy_cnt - r0 !== 1) begin n_err++; $display("FAIL tx_pulses got=%0d exp=1", rdy_cnt - r0); end
    n_cmp++; if (en_cnt !== e0) begin n_err++; $display("FAIL tx_no_ram got=%0d exp=%0d", en_cnt, e0); end
    n_cmp++; if (tx_valid_o !== 1'b0) begin n_err++; $display("FAIL tx_idle got=%0b exp=0", tx_valid_o); end
  endtask

  task automatic test_io_random();
    bit is_wr, got, bad;
    int hs, hs_cyc, p_cyc;
    logic [7:0] w, cap, rd;
    for (int i = 0; i < 12; i++) begin
      is_wr = 1'($urandom); w = 8'($urandom);
      cpu_ioreq_i = 1'b1; cpu_wr_i = is_wr; cpu_rd_i = !is_wr; cpu_mreq_i = 1'($urandom);
      cpu_wdata_i = w; tx_ready_i = 1'b0; rx_valid_i = 1'b0;
      hs = 0; hs_cyc = -10; p_cyc = -1; got = 1'b0; bad = 1'b0; cap = 'x; rd = 'x;
      for (int k = 0; k < 40; k++) begin
        @(negedge clk);
        if (cpu_ready_o) begin got = 1'b1; p_cyc = cyc; rd = cpu_rdata_o; break; end
        if (tx_valid_o && tx_data_o !== w) bad = 1'b1;
        if (tx_valid_o && tx_ready_i) begin hs++; hs_cyc = cyc; end
        if (rx_ready_o && rx_valid_i) begin hs++; hs_cyc = cyc; cap = rx_data_i; end
        @(posedge clk); #1;
        tx_ready_i = 1'($urandom); rx_valid_i = 1'($urandom); rx_data_i = 8'($urandom);
      end
      tx_ready_i = 1'b0; rx_valid_i = 1'b0;
      n_cmp++; if (!got || hs !== 1 || bad || p_cyc !== hs_cyc + 1) begin
        n_err++; $display("FAIL io_rand%0d got=pulse%0b hs=%0d bad=%0b dt=%0d exp=1/1/0/1", i, got, hs, bad,
                          p_cyc - hs_cyc); end
      if (!is_wr) begin
        n_cmp++; if (rd !== cap) begin n_err++; $display("FAIL io_rand_rx%0d got=%h exp=%h", i, rd, cap); end
      end
      @(posedge clk); #1;
      cpu_ioreq_i = 1'b0; cpu_rd_i = 1'b0; cpu_wr_i = 1'b0; cpu_mreq_i = 1'b0;
    end
  endtask

  task automatic test_mem_random();
    int lat;
    bit host, wr;
    logic [7:0] a, d, rd, last_host;
    a = 8'($urandom);
    host_mem(1'b0, a, 8'h00, lat, rd);
    last_host = exp_mem[a];
    n_cmp++; if (rd !== last_host) begin n_err++; $display("FAIL mem_rand_first got=%h exp=%h", rd, last_host); end
    for (int i = 0; i < 40; i++) begin
      host = 1'($urandom); wr = 1'($urandom); a = 8'($urandom); d = 8'($urandom);
      if (host) host_mem(wr, a, d, lat, rd);
      else      cpu_mem(wr ? 1'($urandom) : 1'b1, wr, a, d, lat, rd);
      n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL mem_rand_lat%0d got=%0d exp=3", i, lat); end
      if (wr) begin
        exp_mem[a] = d;
      end else begin
        n_cmp++; if (rd !== exp_mem[a]) begin n_err++; $display("FAIL mem_rand_data%0d got=%h exp=%h", i, rd, exp_mem[a]); end
        if (host) last_host = exp_mem[a];
      end
      if (!host) begin
        n_cmp++; if (host_rdata_o !== last_host) begin
          n_err++; $display("FAIL host_rdata_hold%0d got=%h exp=%h", i, host_rdata_o, last_host); end
      end
    end
  endtask

  task automatic test_latency3();
    int lat, r0;
    logic [7:0] rd, d0, d1;
    r0 = rdy3_cnt; d0 = 8'h77; d1 = 8'($urandom);
    cpu3_mem(1'b1, 8'h22, d0, lat, rd);
    n_cmp++; if (lat !== 5) begin n_err++; $display("FAIL l3_wr_lat got=%0d exp=5", lat); end
    cpu3_mem(1'b0, 8'h22, 8'h00, lat, rd);
    n_cmp++; if (lat !== 5 || rd !== d0) begin n_err++; $display("FAIL l3_rd got=%0d/%h exp=5/%h", lat, rd, d0); end
    cpu3_mem(1'b1, 8'h23, d1, lat, rd);
    cpu3_mem(1'b0, 8'h23, 8'h00, lat, rd);
    n_cmp++; if (lat !== 5 || rd !== d1) begin n_err++; $display("FAIL l3_rd2 got=%0d/%h exp=5/%h", lat, rd, d1); end
    cpu3_mem(1'b0, 8'h22, 8'h00, lat, rd);
    n_cmp++; if (lat !== 5 || rd !== d0) begin n_err++; $display("FAIL l3_rd3 got=%0d/%h exp=5/%h", lat, rd, d0); end
    repeat (3) @(posedge clk); #1;
    n_cmp++; if (rdy3_cnt - r0 !== 5) begin n_err++; $display("FAIL l3_pulses got=%0d exp=5", rdy3_cnt - r0); end
  endtask

  task automatic test_reset_mid();
    int lat, r0, a0;
    logic [7:0] rd;
    cpu_addr_i = 8'h10; cpu_rd_i = 1'b1; cpu_wr_i = 1'b0; cpu_mreq_i = 1'b1;
    repeat (3) @(negedge clk);
    r0 = rdy_cnt; a0 = ack_cnt;
    rst = 1'b1;
    #1;
    n_cmp++; if (outs1 !== '0) begin n_err++; $display("FAIL rst_mid_outs got=%h exp=0", outs1); end
    @(posedge clk); #1;
    cpu_rd_i = 1'b0; cpu_mreq_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk); #1;
    n_cmp++; if (rdy_cnt !== r0 || ack_cnt !== a0) begin
      n_err++; $display("FAIL rst_mid_no_pulse got=%0d/%0d exp=%0d/%0d", rdy_cnt, ack_cnt, r0, a0); end
    cpu_mem(1'b1, 1'b0, 8'h10, 8'h00, lat, rd);
    n_cmp++; if (lat !== 3 || rd !== exp_mem[8'h10]) begin
      n_err++; $display("FAIL rst_mid_recover got=%0d/%h exp=3/%h", lat, rd, exp_mem[8'h10]); end
    n_cmp++; if (we_glitch !== 0) begin n_err++; $display("FAIL ram_we_outside_cmd got=%0d exp=0", we_glitch); end
  endtask

  initial begin
    rst = 1'b1;
    cpu_addr_i = '0; cpu_wdata_i = '0; cpu_rd_i = 1'b0; cpu_wr_i = 1'b0;
    cpu_mreq_i = 1'b0; cpu_ioreq_i = 1'b0;
    host_req_i = 1'b0; host_we_i = 1'b0; host_addr_i = '0; host_wdata_i = '0;
    tx_ready_i = 1'b0; rx_data_i = '0; rx_valid_i = 1'b0;
    c3_addr = '0; c3_wdata = '0; c3_rd = 1'b0; c3_wr = 1'b0; c3_mreq = 1'b0;
    test_reset();
    test_cpu_write_read();
    test_preload();
    test_contention();
    test_io_rx_block();
    test_io_tx();
    test_io_random();
    test_mem_random();
    test_latency3();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/bf_bus_ctrl.md
Name: bf_bus_ctrl

Overview:
Bus controller between brainfuck_cpu-style cores and the system resources. It decodes the CPU strobe bus (mreq/ioreq, rd/wr, ready).
- Memory requests go to a single-port synchronous data RAM, shared round-robin with a host/debug port.
- I/O requests become valid/ready streams to a console TX and RX.
- Every CPU and host transaction ends with a one-cycle ready/ack pulse.

Parameters:
DATA_ADDR_WIDTH, 8, width of the data RAM address (CPU and host).
RAM_LATENCY, 1, synchronous RAM read latency in cycles; legal range 1..4.

Ports:
clk  in  1  clock; all state changes on the rising edge
rst  in  1  reset, asynchronous, active-high
cpu_addr_i  in  DATA_ADDR_WIDTH  CPU data pointer
cpu_wdata_i  in  8  CPU write data (the core's data_o)
cpu_rdata_o  out  8  registered read data to the CPU (the core's data_i)
cpu_rd_i, cpu_wr_i, cpu_mreq_i, cpu_ioreq_i  in  1 each  CPU strobes, held until ready
cpu_ready_o  out  1  one-cycle completion pulse to the CPU
host_req_i  in  1  host request, held until ack
host_we_i  in  1  host write (1) / read (0)
host_addr_i  in  DATA_ADDR_WIDTH  host address
host_wdata_i  in  8  host write data
host_rdata_o  out  8  registered host read data
host_ack_o  out  1  one-cycle host completion pulse
ram_en_o, ram_we_o  out  1 each  RAM strobes
ram_addr_o  out  DATA_ADDR_WIDTH  RAM address
ram_wdata_o  out  8  RAM write data
ram_rdata_i  in  8  RAM read data, valid RAM_LATENCY cycles after ram_en_o
tx_data_o  out  8  console output byte
tx_valid_o  out  1  TX valid
tx_ready_i  in  1  TX ready
rx_data_i  in  8  console input byte
rx_valid_i  in  1  RX valid
rx_ready_o  out  1  RX ready

Behaviour:
- Reset: every output is 0, both FSMs return to idle and last_grant=HOST. Reset mid-transaction abandons it silently, with no ready or ack pulse.
- Request decode: a CPU memory request is cpu_mreq_i & (cpu_rd_i | cpu_wr_i); an I/O request uses ioreq instead.
  - If mreq and ioreq are both high, ioreq wins and mreq is ignored.
  - If rd and wr are both high, wr wins.
- Two independent FSMs. A CPU blocked on I/O never blocks the host's RAM access.
- RAM FSM states: R_IDLE, R_CMD, R_WAIT, R_RESP.
  - R_IDLE: pick one requester. If only one requests, it is granted. If both request, grant the one not equal to last_grant. Latch address, data, write flag and owner, then go to R_CMD.
  - R_CMD (1 cycle): ram_en_o=1, ram_we_o=write flag, ram_addr_o and ram_wdata_o from the latch. Go to R_WAIT.
  - R_WAIT (RAM_LATENCY cycles, counter): ram_en_o=0. On the last cycle, latch ram_rdata_i into the owner's rdata register (reads only). Go to R_RESP.
  - R_RESP (1 cycle): pulse the owner's ready/ack, update last_grant=owner, return to R_IDLE.
  - Latency from request first visible to the ready/ack pulse is RAM_LATENCY+2 cycles (3 at the default), identical for reads and writes.
  - The requester drops or changes its request in the cycle after the pulse. Requests seen in R_RESP are ignored, so a completed request is never double-served.
- Non-owner read data registers hold their value. ram_* outputs are driven from registers (Moore): 0 outside R_CMD, except that address and data may hold their last value.
- I/O FSM states: IO_IDLE, IO_TX, IO_RX, IO_RESP.
  - IO_IDLE + CPU I/O write: latch cpu_wdata_i into tx_data_o, go to IO_TX.
  - IO_IDLE + CPU I/O read: go to IO_RX.
  - IO_TX: tx_valid_o=1. tx_data_o is held stable until the tx_valid_o & tx_ready_i handshake, then go to IO_RESP.
  - IO_RX: rx_ready_o=1. On rx_valid_i, latch rx_data_i into cpu_rdata_o, then go to IO_RESP.
  - IO_RESP: pulse cpu_ready_o, return to IO_IDLE.
  - No timeout; stalls are indefinite by design.
- cpu_ready_o is the OR of the RAM-FSM CPU pulse and the IO_RESP pulse. The two cannot coincide because the CPU has only one outstanding request.
- Non-request cycles (+, -, [, ]) carry no strobes, and the block stays idle.

Decomposition:
- Package bf_bus_pkg:
  - RAM and I/O state encodings.
  - Owner encoding (OWN_CPU, OWN_HOST).
  - Helper constant for the latency counter width, clog2(RAM_LATENCY+1).
- One natural sub-module, bf_rr_arbiter2: a two-requester round-robin grant with last_grant storage, updated on R_RESP. The I/O FSM stays inline.

Test Plan:
- CPU write 0x5A to addr 0x10, no host traffic -> ram_en=ram_we=1 for exactly 1 cycle with addr 0x10 and data 0x5A; cpu_ready_o pulses 3 cycles after the request (RAM_LATENCY=1). Then a CPU read of 0x10 -> cpu_rdata_o=0x5A at the ready pulse.
- CPU and host both request reads in the same cycle after reset -> CPU served first, host ack follows in the next transaction. Repeat persistent contention -> strict alternation.
- CPU holds an I/O read with rx_valid low for 20 cycles while the host writes 0xFF to 0x03 -> host_ack arrives at normal latency. Then rx_valid with 0x41 -> cpu_rdata_o=0x41 and cpu_ready_o pulses once.
- CPU I/O write 0x48 with tx_ready low for 5 cycles -> tx_valid held high and tx_data stable at 0x48; handshake, then one cpu_ready_o pulse.
- RAM_LATENCY=3 build, CPU read -> ready at cycle 5; a write immediately followed by a read (brainfuck_cpu '>' sequence) -> both served, no double pulse.
- rst asserted in R_WAIT -> all outputs 0 immediately, no ack; after release a new request completes normally.
